// File: rtl/sobel_gradient.sv
// sobel_gradient
//   Streaming 3x3 Sobel stage. Consumes a raster-order 8-bit grayscale
//   stream, keeps two line buffers plus a 3x3 window, and emits signed
//   vertical (Gy) and horizontal (Gx) gradients for every interior pixel
//   whose full window lies inside the frame.
//
// Ports
//   clk             rising-edge system clock
//   reset_n         asynchronous active-low reset
//   pixel_in        unsigned grayscale pixel
//   pixel_valid     pixel_in accepted this cycle
//   start_of_frame  with pixel_valid, marks pixel (row 0, col 0)
//   vert_out        signed Gy (bottom row minus top row), PRECISION bits
//   horz_out        signed Gx (right column minus left column), PRECISION bits
//   grad_valid      vert_out/horz_out carry a new result this cycle
//   frame_done      pulses with the last gradient of a frame
module sobel_gradient #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int PRECISION = 24
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  pixel_in,
  input  logic                        pixel_valid,
  input  logic                        start_of_frame,
  output logic signed [PRECISION-1:0] vert_out,
  output logic signed [PRECISION-1:0] horz_out,
  output logic                        grad_valid,
  output logic                        frame_done
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // Line buffers: no reset; gating on row/col keeps stale contents out
  logic [7:0] lb0 [WIDTH];
  logic [7:0] lb1 [WIDTH];

  // Window: w[r][c], r=0 top (oldest row), c=0 left (oldest column)
  logic [7:0] w [3][3];

  logic                sof;
  logic [CW-1:0]       cur_col;
  logic [RW-1:0]       cur_row;
  logic [7:0]          tap_top;
  logic [7:0]          tap_mid;
  logic                emit;
  logic                last_pix;
  logic signed [10:0]  horz_nx;
  logic signed [10:0]  vert_nx;

  function automatic logic signed [10:0] z1(input logic [7:0] p);
    return {3'b000, p};
  endfunction

  function automatic logic signed [10:0] z2(input logic [7:0] p);
    return {2'b00, p, 1'b0};
  endfunction

  // A qualified start_of_frame overrides the counters for this pixel
  assign sof     = pixel_valid & start_of_frame;
  assign cur_col = sof ? '0 : col;
  assign cur_row = sof ? '0 : row;
  assign tap_top = lb1[cur_col];
  assign tap_mid = lb0[cur_col];

  assign emit     = pixel_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  // Gradients are evaluated on the window as it will be after this shift,
  // so the registered result lands one cycle after the accepting edge.
  // Post-shift: c0 <- w[*][1], c1 <- w[*][2], c2 <- {tap_top, tap_mid, pixel_in}.
  always_comb begin
    horz_nx = '0;
    vert_nx = '0;
    horz_nx = (z1(tap_top)  + z2(tap_mid)  + z1(pixel_in))
            - (z1(w[0][1])  + z2(w[1][1])  + z1(w[2][1]));
    vert_nx = (z1(w[2][1])  + z2(w[2][2])  + z1(pixel_in))
            - (z1(w[0][1])  + z2(w[0][2])  + z1(tap_top));
  end

  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col        <= '0;
      row        <= '0;
      vert_out   <= '0;
      horz_out   <= '0;
      grad_valid <= 1'b0;
      frame_done <= 1'b0;
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          w[r][c] <= '0;
        end
      end
    end else begin
      grad_valid <= 1'b0;
      frame_done <= 1'b0;
      if (pixel_valid) begin
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end

        for (int unsigned r = 0; r < 3; r++) begin
          w[r][0] <= w[r][1];
          w[r][1] <= w[r][2];
        end
        w[0][2] <= tap_top;
        w[1][2] <= tap_mid;
        w[2][2] <= pixel_in;

        if (emit) begin
          vert_out   <= PRECISION'(vert_nx);
          horz_out   <= PRECISION'(horz_nx);
          grad_valid <= 1'b1;
          frame_done <= last_pix;
        end
      end
    end
  end

endmodule

// File: doc/sobel_gradient.md
# sobel_gradient

Streaming 3x3 Sobel convolution stage that sits directly upstream of the gradient-magnitude block. It accepts a raster-order 8-bit grayscale pixel stream, buffers two image lines, and emits signed vertical and horizontal gradients at PRECISION bits, ready to drive the magnitude block's `vert_in`/`horz_in`. Output is produced only for interior pixels whose full 3x3 window lies inside the frame.

## Interface
- `WIDTH`, 640, pixels per line (>= 3)
- `HEIGHT`, 480, lines per frame (>= 3)
- `PRECISION`, 24, width of the signed gradient outputs (>= 11)

- `clk`  in  1  system clock; all logic on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `pixel_in`  in  8  unsigned grayscale pixel
- `pixel_valid`  in  1  `pixel_in` is accepted this cycle
- `start_of_frame`  in  1  qualified by `pixel_valid`; marks pixel (row 0, col 0)
- `vert_out`  out  PRECISION  signed Gy, bottom row minus top row
- `horz_out`  out  PRECISION  signed Gx, right column minus left column
- `grad_valid`  out  1  `vert_out`/`horz_out` hold a new result this cycle
- `frame_done`  out  1  one-cycle pulse with the last gradient of a frame

## Operation
- Counters: `col` runs 0..WIDTH-1 and `row` runs 0..HEIGHT-1. Both advance only on accepted pixels. `col` wraps to 0 and increments `row`. After (HEIGHT-1, WIDTH-1), both wrap to (0,0).
- `start_of_frame` with `pixel_valid` forces the current pixel to (0,0), regardless of counter state. This includes mid-frame restarts. The next pixel is then (0,1).
- Line buffers: two WIDTH x 8 memories, lb0 (row-1) and lb1 (row-2), addressed by `col`. They have no reset. On each accepted pixel:
  - tap_top = lb1[col] and tap_mid = lb0[col]
  - lb1[col] <= lb0[col] and lb0[col] <= `pixel_in`
- Window: 3x3 registers w[r][c]. r=0 is the top (oldest) row; c=0 is the left (oldest) column. They reset to 0.
  - On an accepted pixel, columns shift left and the new column {tap_top, tap_mid, `pixel_in`} enters at c=2.
  - The window is not cleared at line starts. Output gating excludes windows that straddle a line or frame boundary.
- Arithmetic, in 11-bit signed with operands zero-extended:
  - horz = (w02 + 2·w12 + w22) − (w00 + 2·w10 + w20)
  - vert = (w20 + 2·w21 + w22) − (w00 + 2·w01 + w02)
  - The range is ±1020, so there is no overflow. Results are sign-extended to PRECISION.
- Emit condition: the accepted pixel has row >= 2 and col >= 2, where row and col are the values before the increment. The result is centred on (row−1, col−1).
- Output count is (WIDTH−2)·(HEIGHT−2) per complete frame.
- `frame_done` is asserted with the output for pixel (HEIGHT−1, WIDTH−1).

## Timing
- Latency: the result appears on the cycle after the accepting edge of the pixel that completes the window. `grad_valid` is high for exactly that one cycle.
- `pixel_valid` low: nothing shifts and the counters hold. `grad_valid` goes low the next cycle. `vert_out`/`horz_out` hold their last value.
- Back-to-back valid pixels give one result per cycle; there is no backpressure. The downstream block must accept every `grad_valid`.
- Reset values: `vert_out` = 0, `horz_out` = 0, `grad_valid` = 0, `frame_done` = 0, `row` = `col` = 0, window = 0.
- Reset mid-frame: the next accepted pixel is (0,0). No output is emitted until row 2, col 2 of the new frame. Stale line-buffer data is never emitted.
- `start_of_frame` on an accepted pixel that would otherwise be (0,0): no special effect.
- `start_of_frame` without `pixel_valid`: ignored.

## Test plan
Use WIDTH=8, HEIGHT=6, PRECISION=24, and a continuous stream unless stated otherwise.
- Constant frame, all pixels 100 -> 24 results, all with vert=0 and horz=0. `frame_done` is high on the 24th result only.
- Horizontal ramp, pixel=10·col -> every result has horz=+80 and vert=0. The first `grad_valid` occurs one cycle after pixel (2,2) is accepted.
- Vertical ramp, pixel=10·row -> every result has vert=+80 and horz=0.
- Step edge, cols 0–3 = 0 and cols 4–7 = 255:
  - centres at col 3 and col 4 -> horz=+1020 (0x0003FC)
  - all other results -> 0
  - vert=0 throughout
- Horizontal ramp with `pixel_valid` toggling 1-0-1 and random 0–3 cycle gaps -> same 24 values as the gap-free run. Outputs hold during gaps, and `grad_valid` never lasts more than one cycle per accepted pixel.
- `start_of_frame` after 3.5 rows, then a full constant-50 frame; separately, `reset_n` pulsed low mid-frame then a full frame -> outputs all 0 during reset. Each restarted frame yields exactly 24 results of 0/0, with no results from the stale partial frame.
